finalsoc_key_edge: RTL and testbench

FINALSOC_KEY_EDGE -- requirements
Module: finalsoc_key_edge

---
 rtl/finalsoc_key_edge_pkg.sv | 30 +++
 rtl/finalsoc_key_debounce.sv | 52 +++++
 rtl/finalsoc_key_edge.sv | 84 ++++++++
 tb/tb_finalsoc_key_edge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/finalsoc_key_edge_pkg.sv
// Shared constants and helpers for the debounced key edge-capture peripheral.
package finalsoc_key_edge_pkg;

    localparam int unsigned REG_W = 32;

    // Edge qualification modes
    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    // Register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // True when the transition last -> cur matches the selected edge mode
    function automatic logic edge_hit(input logic cur, input logic last,
                                      input int unsigned edge_type);
        logic rise;
        logic fall;
        rise = cur & ~last;
        fall = ~cur & last;
        case (edge_type)
            EDGE_RISING:  return rise;
            EDGE_FALLING: return fall;
            default:      return rise | fall;
        endcase
    endfunction

endpackage

// File: rtl/finalsoc_key_debounce.sv
// One key channel: 2-flop synchronizer followed by a stability counter that
// moves the debounced level only after DEBOUNCE_CYCLES consecutive differing samples.
module finalsoc_key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    output logic debounced
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             deb_nxt;

    // Counter restarts on any agreement; the final differing sample commits the level
    always_comb begin
        cnt_nxt = '0;
        deb_nxt = debounced;
        if (sync_q2 != debounced) begin
            if (cnt == CNT_FIRE) begin
                deb_nxt = sync_q2;
            end else if (cnt != CNT_MAX) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                cnt_nxt = cnt;
            end
        end
    end

    // Keys idle high, so the debounced level resets to 1
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            cnt       <= '0;
            debounced <= 1'b1;
        end else begin
            sync_q1   <= key;
            sync_q2   <= sync_q1;
            cnt       <= cnt_nxt;
            debounced <= deb_nxt;
        end
    end

endmodule

// File: rtl/finalsoc_key_edge.sv
// Debounced key input port with sticky edge capture, interrupt mask and a
// small memory-mapped register interface.
module finalsoc_key_edge
    import finalsoc_key_edge_pkg::*;
#(
    parameter int unsigned WIDTH           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = EDGE_FALLING
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [REG_W-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [REG_W-1:0] readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] hit_c;
    logic [WIDTH-1:0] capture;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] capture_nxt_c;
    logic [REG_W-1:0] rd_c;
    logic             wr_en_c;
    logic             unused_wdata_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        finalsoc_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .reset_n  (reset_n),
            .key      (in_port[i]),
            .debounced(deb[i])
        );
        assign hit_c[i] = edge_hit(deb[i], deb_q[i], EDGE_TYPE);
    end

    assign wr_en_c        = chipselect & ~write_n;
    assign unused_wdata_c = ^writedata;

    // A new edge wins over a same-cycle write-1-to-clear
    always_comb begin
        clr_c = '0;
        if (wr_en_c && (address == ADDR_EDGE)) begin
            clr_c = writedata[WIDTH-1:0];
        end
        capture_nxt_c = (capture & ~clr_c) | hit_c;
    end

    always_comb begin
        rd_c = '0;
        case (address)
            ADDR_DATA: rd_c = REG_W'(deb);
            ADDR_MASK: rd_c = REG_W'(mask);
            ADDR_EDGE: rd_c = REG_W'(capture);
            default:   rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_q    <= '1;
            mask     <= '0;
            capture  <= '0;
            readdata <= '0;
        end else begin
            deb_q    <= deb;
            capture  <= capture_nxt_c;
            readdata <= rd_c;
            if (wr_en_c && (address == ADDR_MASK)) begin
                mask <= writedata[WIDTH-1:0];
            end
        end
    end

    assign irq = |(capture & mask);

endmodule

// File: tb/tb_finalsoc_key_edge.sv
// Bench for finalsoc_key_edge: falling-edge and any-edge instances share stimulus
// and are compared every cycle against a history-based reference model.
module tb_finalsoc_key_edge;
    import finalsoc_key_edge_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned DB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd_f;
    logic [31:0]   rd_a;
    logic          irq_f;
    logic          irq_a;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    finalsoc_key_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(EDGE_FALLING)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_f), .irq(irq_f)
    );

    finalsoc_key_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(EDGE_ANY)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    // Reference model: index 0 = falling-edge instance, 1 = any-edge instance
    logic [W-1:0]  m_deb;
    logic [W-1:0]  m_prev;
    logic [W-1:0]  m_cap  [2];
    logic [W-1:0]  m_mask [2];
    logic [31:0]   m_rd   [2];
    logic [W-1:0]  m_samp [$];
    logic [W-1:0]  m_seen [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_deb  = '1;
        m_prev = '1;
        for (int k = 0; k < 2; k++) begin
            m_cap[k]  = '0;
            m_mask[k] = '0;
            m_rd[k]   = '0;
        end
        m_samp.delete();
        m_seen.delete();
    endfunction

    // One rising edge: level seen by the debouncer is the pin level from two edges ago;
    // a channel flips once its last DB seen levels all disagree with it.
    function automatic void model_tick();
        logic [W-1:0] rise, fall, ev, clr, seen;
        logic         wr;
        logic         all_diff;
        rise = m_deb & ~m_prev;
        fall = ~m_deb & m_prev;
        wr   = chipselect && !write_n;
        for (int k = 0; k < 2; k++) begin
            case (address)
                2'd0:    m_rd[k] = 32'(m_deb);
                2'd2:    m_rd[k] = 32'(m_mask[k]);
                2'd3:    m_rd[k] = 32'(m_cap[k]);
                default: m_rd[k] = 32'd0;
            endcase
            ev  = (k == 0) ? fall : (rise | fall);
            clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            if (wr && address == 2'd2) m_mask[k] = writedata[W-1:0];
            m_cap[k] = (m_cap[k] & ~clr) | ev;
        end
        m_prev = m_deb;
        seen = (m_samp.size() >= 2) ? m_samp[m_samp.size() - 2] : '0;
        m_samp.push_back(in_port);
        if (m_samp.size() > 2) void'(m_samp.pop_front());
        m_seen.push_back(seen);
        if (m_seen.size() > DB) void'(m_seen.pop_front());
        if (m_seen.size() == DB) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (m_seen[j]) if (m_seen[j][i] == m_deb[i]) all_diff = 1'b0;
                if (all_diff) m_deb[i] = ~m_deb[i];
            end
        end
    endfunction

    task automatic step(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            if (reset_n) model_tick();
            else model_reset();
            @(negedge clk);
            check("model_rd_fall", rd_f, m_rd[0]);
            check("model_rd_any", rd_a, m_rd[1]);
            check("model_irq_fall", 32'(irq_f), 32'(|(m_cap[0] & m_mask[0])));
            check("model_irq_any", 32'(irq_a), 32'(|(m_cap[1] & m_mask[1])));
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_rd", rd_f | rd_a, 32'd0);
        check("async_rst_irq", 32'(irq_f | irq_a), 32'd0);
        step(2);
        reset_n = 1'b1;
    endtask

    initial begin
        int hold;
        reset_n    = 1'b1;
        in_port    = '1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("reset_rd", rd_f, 32'd0);
        check("reset_irq", 32'(irq_f), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset values as seen through the bus
        step(1);
        check("rst_data", rd_f, 32'h3);
        address = 2'd3;
        step(1);
        check("rst_edge", rd_f, 32'h0);
        check("rst_irq", 32'(irq_f), 32'd0);

        // 3-cycle glitch on bit 1 must be rejected
        address = 2'd0;
        in_port[1] = 1'b0;
        step(3);
        in_port[1] = 1'b1;
        step(8);
        check("glitch_data", rd_f, 32'h3);
        address = 2'd3;
        step(1);
        check("glitch_edge", rd_f, 32'h0);
        check("glitch_edge_any", rd_a, 32'h0);

        // Clean press on bit 0: debounced after 6 edges, readdata one later, capture next
        address = 2'd0;
        in_port[0] = 1'b0;
        step(6);
        check("db_hold", rd_f, 32'h3);
        step(1);
        check("db_data", rd_f, 32'h2);
        address = 2'd3;
        step(1);
        check("db_edge", rd_f, 32'h1);

        // Mask then write-1-to-clear
        check("irq_unmasked", 32'(irq_f), 32'd0);
        bus_write(2'd2, 32'h1);
        check("irq_set", 32'(irq_f), 32'd1);
        address = 2'd2;
        step(1);
        check("mask_read", rd_f, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_clr", 32'(irq_f), 32'd0);
        step(1);
        check("clr_edge", rd_f, 32'h0);

        // Writes to data/reserved addresses change nothing
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_write(2'd1, 32'hFFFF_FFFF);
        address = 2'd2;
        step(1);
        check("ro_mask", rd_f, 32'h1);
        address = 2'd1;
        step(1);
        check("rsvd_zero", rd_f, 32'h0);

        // Edge on bit 1 lands in the same cycle as a clear of bit 1
        in_port[1] = 1'b0;
        step(6);
        bus_write(2'd3, 32'h2);
        step(1);
        check("simul_edge", rd_f, 32'h2);
        check("simul_irq", 32'(irq_f), 32'd0);

        // Any-edge mode: release then press on bit 0
        bus_write(2'd3, 32'hFFFF_FFFF);
        in_port[0] = 1'b1;
        step(7);
        step(1);
        check("any_rel_any", rd_a, 32'h1);
        check("any_rel_fall", rd_f, 32'h0);
        check("any_rel_irq", 32'(irq_a), 32'd1);
        bus_write(2'd3, 32'h1);
        in_port[0] = 1'b0;
        step(8);
        check("any_press_any", rd_a, 32'h1);
        check("any_press_fall", rd_f, 32'h1);

        // Mid-debounce reset abandons the count
        in_port[0] = 1'b1;
        step(3);
        pulse_reset();
        address = 2'd0;
        step(4);
        check("rst_mid_data", rd_f, 32'h3);

        // Randomized traffic against the model
        hold = 0;
        for (int t = 0; t < 3000; t++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold    = int'($urandom_range(1, 12));
            end
            hold--;
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
